// File: rtl/arm_exec_unit.sv
// arm_exec_unit
// ---------------------------------------------------------------------------
// Execute stage for the ARM32 core. Evaluates the condition field against the
// held NZCV register, performs the sixteen ARM data-processing operations on
// two pre-decoded operands and presents the result through a one-entry output
// register with valid/ready back-pressure.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   instruction handshake from decode/operand fetch
//   op, cond, s, rd       opcode ins[24:21], condition ins[31:28], S bit, Rd
//   a, b                  Rn and the already shifted/expanded second operand
//   sh_c                  shifter carry-out, used as C by logical ops
//   flags_ld, flags_in    direct NZCV load (MSR path)
//   out_valid / out_ready result handshake towards writeback
//   result, out_rd, wr_en registered result, destination, writeback enable
//   flags                 current NZCV register {N,Z,C,V}
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer holds its payload stable while valid && !ready. in_ready is
// combinational: the output register can take a new entry when it is empty
// or is being drained in the same cycle.
// ---------------------------------------------------------------------------
module arm_exec_unit #(
  parameter int N  = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op,
  input  logic [3:0]    cond,
  input  logic          s,
  input  logic [RW-1:0] rd,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          sh_c,
  input  logic          flags_ld,
  input  logic [3:0]    flags_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  result,
  output logic [RW-1:0] out_rd,
  output logic          wr_en,
  output logic [3:0]    flags
);

  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  result_q, result_d;
  logic [RW-1:0] out_rd_q, out_rd_d;
  logic          wr_en_q, wr_en_d;
  logic [3:0]    flags_q, flags_d;

  logic nf, zf, cf, vf;
  assign {nf, zf, cf, vf} = flags_q;

  logic acc;
  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;

  // Condition evaluation against the currently held flags.
  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = zf;
      4'b0001: cond_pass = !zf;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = !cf;
      4'b0100: cond_pass = nf;
      4'b0101: cond_pass = !nf;
      4'b0110: cond_pass = vf;
      4'b0111: cond_pass = !vf;
      4'b1000: cond_pass = cf && !zf;
      4'b1001: cond_pass = !cf || zf;
      4'b1010: cond_pass = (nf == vf);
      4'b1011: cond_pass = (nf != vf);
      4'b1100: cond_pass = !zf && (nf == vf);
      4'b1101: cond_pass = zf || (nf != vf);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // All arithmetic ops share one adder; the opcode only selects the adder
  // inputs (x, y, cin). Logical ops bypass the adder.
  logic [N-1:0] x, y, res_logic;
  logic         cin, logical;
  always_comb begin
    x         = a;
    y         = b;
    cin       = 1'b0;
    logical   = 1'b1;
    res_logic = '0;
    case (op)
      4'b0000, 4'b1000: res_logic = a & b;
      4'b0001, 4'b1001: res_logic = a ^ b;
      4'b0010, 4'b1010: begin x = a; y = ~b; cin = 1'b1; logical = 1'b0; end
      4'b0011:          begin x = b; y = ~a; cin = 1'b1; logical = 1'b0; end
      4'b0100, 4'b1011: begin x = a; y = b;  cin = 1'b0; logical = 1'b0; end
      4'b0101:          begin x = a; y = b;  cin = cf;   logical = 1'b0; end
      4'b0110:          begin x = a; y = ~b; cin = cf;   logical = 1'b0; end
      4'b0111:          begin x = b; y = ~a; cin = cf;   logical = 1'b0; end
      4'b1100:          res_logic = a | b;
      4'b1101:          res_logic = b;
      4'b1110:          res_logic = a & ~b;
      default:          res_logic = ~b;
    endcase
  end

  logic [N:0]   sum;
  logic [N-1:0] alu_res;
  logic [3:0]   alu_flags;
  assign sum     = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
  assign alu_res = logical ? res_logic : sum[N-1:0];

  always_comb begin
    alu_flags[3] = alu_res[N-1];
    alu_flags[2] = (alu_res == '0);
    alu_flags[1] = logical ? sh_c : sum[N];
    alu_flags[0] = logical ? vf
                           : ((x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]));
  end

  // TST/TEQ/CMP/CMN (1000-1011) always set flags and never write back.
  logic is_test;
  assign is_test = (op[3:2] == 2'b10);

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_rd_d    = out_rd_q;
    wr_en_d     = wr_en_q;
    flags_d     = flags_q;

    if (acc) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      out_rd_d    = rd;
      wr_en_d     = cond_pass && !is_test;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // An accepted flag-setting instruction takes priority over the MSR load.
    if (acc && cond_pass && (s || is_test)) begin
      flags_d = alu_flags;
    end else if (flags_ld) begin
      flags_d = flags_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_rd_q    <= '0;
      wr_en_q     <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_rd_q    <= out_rd_d;
      wr_en_q     <= wr_en_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_rd    = out_rd_q;
  assign wr_en     = wr_en_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_arm_exec_unit.sv
// Testbench for arm_exec_unit: table of directed single-instruction vectors
// plus hand-written sequences for back-to-back, back-pressure and reset.
module tb_arm_exec_unit;

  localparam int N  = 32;
  localparam int RW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0, cond = '0;
  logic          s = 1'b0;
  logic [RW-1:0] rd = '0;
  logic [N-1:0]  a = '0, b = '0;
  logic          sh_c = 1'b0;
  logic          flags_ld = 1'b0;
  logic [3:0]    flags_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  result;
  logic [RW-1:0] out_rd;
  logic          wr_en;
  logic [3:0]    flags;

  arm_exec_unit #(.N(N), .RW(RW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cond(cond), .s(s), .rd(rd), .a(a), .b(b), .sh_c(sh_c),
    .flags_ld(flags_ld), .flags_in(flags_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_rd(out_rd), .wr_en(wr_en), .flags(flags)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at posedge+1.
  task automatic load_flags(input logic [3:0] f);
    flags_ld = 1'b1; flags_in = f;
    @(posedge clk); #1;
    flags_ld = 1'b0;
  endtask

  task automatic drive(input logic [3:0] o, input logic [3:0] c, input logic sv,
                       input logic [RW-1:0] r, input logic [N-1:0] av,
                       input logic [N-1:0] bv, input logic shc);
    op = o; cond = c; s = sv; rd = r; a = av; b = bv; sh_c = shc;
    in_valid = 1'b1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [3:0] c, input logic sv,
                       input logic [RW-1:0] r, input logic [N-1:0] av,
                       input logic [N-1:0] bv, input logic shc);
    drive(o, c, sv, r, av, bv, shc);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  logic mon_en = 1'b0;
  int consumed = 0;

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      consumed++;
      if (exp_q.size() == 0) check("sb_unexpected_result", 64'(result), 64'hDEAD);
      else check("sb_result", 64'(result), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]   pre_flags;
    logic [3:0]   op;
    logic [3:0]   cond;
    logic         s;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sh_c;
    logic [N-1:0] exp_res;
    logic         exp_wr;
    logic [3:0]   exp_flags;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] pf, logic [3:0] o, logic [3:0] c, logic sv,
                              logic [N-1:0] av, logic [N-1:0] bv, logic shc,
                              logic [N-1:0] er, logic ew, logic [3:0] ef);
    vec_t v;
    v.pre_flags = pf; v.op = o; v.cond = c; v.s = sv; v.a = av; v.b = bv;
    v.sh_c = shc; v.exp_res = er; v.exp_wr = ew; v.exp_flags = ef;
    return v;
  endfunction

  initial begin
    //               pre     op     cond   s  a             b             shc res          wr flags
    vecs.push_back(mk(4'h0, 4'h4, 4'hE, 1, 32'h7FFFFFFF, 32'h1,        0, 32'h80000000, 1, 4'b1001)); // ADDS
    vecs.push_back(mk(4'h2, 4'h5, 4'hE, 1, 32'hFFFFFFFF, 32'h0,        0, 32'h0,        1, 4'b0110)); // ADCS
    vecs.push_back(mk(4'h0, 4'h6, 4'hE, 1, 32'h0,        32'h0,        0, 32'hFFFFFFFF, 1, 4'b1000)); // SBCS
    vecs.push_back(mk(4'h1, 4'h0, 4'hE, 1, 32'hF0,       32'h0F,       1, 32'h0,        1, 4'b0111)); // ANDS
    vecs.push_back(mk(4'h0, 4'hA, 4'hE, 0, 32'h5,        32'h5,        0, 32'h0,        0, 4'b0110)); // CMP
    vecs.push_back(mk(4'hF, 4'h2, 4'hE, 0, 32'h3,        32'h5,        0, 32'hFFFFFFFE, 1, 4'b1111)); // SUB
    vecs.push_back(mk(4'h0, 4'h3, 4'hE, 1, 32'h3,        32'h5,        0, 32'h2,        1, 4'b0010)); // RSBS
    vecs.push_back(mk(4'h0, 4'h7, 4'hE, 1, 32'h3,        32'h5,        0, 32'h1,        1, 4'b0010)); // RSCS
    vecs.push_back(mk(4'h1, 4'h1, 4'hE, 1, 32'hFF00,     32'h0F0F,     0, 32'hF00F,     1, 4'b0001)); // EORS
    vecs.push_back(mk(4'h4, 4'hC, 4'hE, 0, 32'hF0,       32'h0F,       0, 32'hFF,       1, 4'b0100)); // ORR
    vecs.push_back(mk(4'h0, 4'hD, 4'hE, 1, 32'h0,        32'h80000000, 1, 32'h80000000, 1, 4'b1010)); // MOVS
    vecs.push_back(mk(4'h8, 4'hE, 4'hE, 1, 32'hFF,       32'h0F,       0, 32'hF0,       1, 4'b0000)); // BICS
    vecs.push_back(mk(4'h0, 4'hF, 4'hE, 1, 32'h0,        32'h0,        0, 32'hFFFFFFFF, 1, 4'b1000)); // MVNS
    vecs.push_back(mk(4'h0, 4'h8, 4'hE, 0, 32'h1,        32'h2,        1, 32'h0,        0, 4'b0110)); // TST
    vecs.push_back(mk(4'h1, 4'h9, 4'hE, 0, 32'h5,        32'h5,        0, 32'h0,        0, 4'b0101)); // TEQ
    vecs.push_back(mk(4'h0, 4'hB, 4'hE, 0, 32'hFFFFFFFF, 32'h1,        0, 32'h0,        0, 4'b0110)); // CMN
    // condition codes: ADD 1+1, flags untouched
    vecs.push_back(mk(4'b0100, 4'h4, 4'h0, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b0100)); // EQ pass
    vecs.push_back(mk(4'b0100, 4'h4, 4'h1, 0, 32'h1, 32'h1, 0, 32'h2, 0, 4'b0100)); // NE fail
    vecs.push_back(mk(4'b0010, 4'h4, 4'h2, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b0010)); // CS pass
    vecs.push_back(mk(4'b0010, 4'h4, 4'h3, 0, 32'h1, 32'h1, 0, 32'h2, 0, 4'b0010)); // CC fail
    vecs.push_back(mk(4'b1000, 4'h4, 4'h4, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b1000)); // MI pass
    vecs.push_back(mk(4'b1000, 4'h4, 4'h5, 0, 32'h1, 32'h1, 0, 32'h2, 0, 4'b1000)); // PL fail
    vecs.push_back(mk(4'b0001, 4'h4, 4'h6, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b0001)); // VS pass
    vecs.push_back(mk(4'b0000, 4'h4, 4'h7, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b0000)); // VC pass
    vecs.push_back(mk(4'b0010, 4'h4, 4'h8, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b0010)); // HI pass
    vecs.push_back(mk(4'b0110, 4'h4, 4'h8, 0, 32'h1, 32'h1, 0, 32'h2, 0, 4'b0110)); // HI fail
    vecs.push_back(mk(4'b0110, 4'h4, 4'h9, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b0110)); // LS pass
    vecs.push_back(mk(4'b1001, 4'h4, 4'hA, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b1001)); // GE pass
    vecs.push_back(mk(4'b1000, 4'h4, 4'hB, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b1000)); // LT pass
    vecs.push_back(mk(4'b0000, 4'h4, 4'hC, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b0000)); // GT pass
    vecs.push_back(mk(4'b0100, 4'h4, 4'hC, 0, 32'h1, 32'h1, 0, 32'h2, 0, 4'b0100)); // GT fail
    vecs.push_back(mk(4'b0001, 4'h4, 4'hD, 0, 32'h1, 32'h1, 0, 32'h2, 1, 4'b0001)); // LE pass
    vecs.push_back(mk(4'b0000, 4'h4, 4'hF, 0, 32'h1, 32'h1, 0, 32'h2, 0, 4'b0000)); // NV
    // failed condition with S set leaves flags alone
    vecs.push_back(mk(4'b0100, 4'h4, 4'h1, 1, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 4'b0100));

    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_out_rd",    64'(out_rd),    64'd0);
    check("rst_wr_en",     64'(wr_en),     64'd0);
    check("rst_flags",     64'(flags),     64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      logic [RW-1:0] r;
      r = RW'(i);
      load_flags(vecs[i].pre_flags);
      issue(vecs[i].op, vecs[i].cond, vecs[i].s, r, vecs[i].a, vecs[i].b, vecs[i].sh_c);
      check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d_result", i),    64'(result),    64'(vecs[i].exp_res));
      check($sformatf("v%0d_out_rd", i),    64'(out_rd),    64'(r));
      check($sformatf("v%0d_wr_en", i),     64'(wr_en),     64'(vecs[i].exp_wr));
      check($sformatf("v%0d_flags", i),     64'(flags),     64'(vecs[i].exp_flags));
    end

    // ---------------- CMP, ADDEQ, ADDNE back-to-back ----------------
    load_flags(4'b0000);
    drive(4'hA, 4'hE, 1'b0, 4'd1, 32'd5, 32'd5, 1'b0);
    @(posedge clk); #1;
    check("b2b_cmp_flags", 64'(flags), 64'b0110);
    check("b2b_cmp_wr_en", 64'(wr_en), 64'd0);
    drive(4'h4, 4'h0, 1'b0, 4'd2, 32'd1, 32'd2, 1'b0);
    @(posedge clk); #1;
    check("b2b_addeq_result", 64'(result), 64'd3);
    check("b2b_addeq_wr_en",  64'(wr_en),  64'd1);
    drive(4'h4, 4'h1, 1'b0, 4'd3, 32'd1, 32'd2, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_addne_wr_en",     64'(wr_en),     64'd0);
    check("b2b_addne_out_valid", 64'(out_valid), 64'd1);

    // ---------------- simultaneous flags_ld and CMP ----------------
    load_flags(4'b0000);
    flags_ld = 1'b1; flags_in = 4'b1111;
    issue(4'hA, 4'hE, 1'b0, 4'd4, 32'd5, 32'd5, 1'b0);
    flags_ld = 1'b0;
    check("ldcmp_flags", 64'(flags), 64'b0110);

    // ---------------- back-pressure ----------------
    load_flags(4'b0000);
    mon_en = 1'b1;
    out_ready = 1'b0;
    exp_q.push_back(32'd11);
    issue(4'h4, 4'hE, 1'b0, 4'd1, 32'd10, 32'd1, 1'b0);
    check("bp_first_valid", 64'(out_valid), 64'd1);
    drive(4'h4, 4'hE, 1'b1, 4'd2, 32'h7FFFFFFF, 32'h1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_stall%0d_in_ready", k), 64'(in_ready), 64'd0);
      check($sformatf("bp_stall%0d_result", k),   64'(result),   64'd11);
      check($sformatf("bp_stall%0d_out_rd", k),   64'(out_rd),   64'd1);
      check($sformatf("bp_stall%0d_flags", k),    64'(flags),    64'd0);
    end
    flags_ld = 1'b1; flags_in = 4'b0011;
    @(posedge clk); #1;
    flags_ld = 1'b0;
    check("bp_stall_flags_ld", 64'(flags),  64'b0011);
    check("bp_stall_held",     64'(result), 64'd11);
    out_ready = 1'b1;
    exp_q.push_back(32'h80000000);
    @(posedge clk); #1;
    check("bp_release_result", 64'(result), 64'h80000000);
    check("bp_release_flags",  64'(flags),  64'b1001);
    exp_q.push_back(32'd7);
    drive(4'h4, 4'hE, 1'b0, 4'd3, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_result", 64'(result), 64'd7);
    check("bp_next_out_rd", 64'(out_rd), 64'd3);
    @(posedge clk); #1;
    check("bp_drained_valid", 64'(out_valid), 64'd0);
    check("bp_queue_empty",   64'(exp_q.size()), 64'd0);
    check("bp_consumed",      64'(consumed), 64'd3);
    mon_en = 1'b0;

    // ---------------- reset mid-stall ----------------
    out_ready = 1'b0;
    issue(4'hA, 4'hE, 1'b0, 4'd5, 32'd5, 32'd5, 1'b0);
    check("rs_pre_valid", 64'(out_valid), 64'd1);
    check("rs_pre_flags", 64'(flags),     64'b0110);
    #2;
    reset_n = 1'b0;
    #1;
    check("rs_out_valid", 64'(out_valid), 64'd0);
    check("rs_flags",     64'(flags),     64'd0);
    check("rs_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk) reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rs_after_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
